// File: rtl/team_09_pkg.sv
// Shared definitions for the team_09 input-conditioning logic: debounce FSM
// state encodings and the default debounce length used by the core.
package team_09_pkg;

    typedef enum logic [1:0] {
        DB_LOW    = 2'd0,
        DB_CHK_HI = 2'd1,
        DB_HIGH   = 2'd2,
        DB_CHK_LO = 2'd3
    } db_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 256;

endpackage

// File: rtl/team_09_debounce_chan.sv
// One conditioned input channel: synchroniser chain, debounce FSM with a
// stability counter, registered clean level, rise/fall pulses and sticky flag.
module team_09_debounce_chan
    import team_09_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic pad_i,
    input  logic sticky_clr_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic sticky_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             sticky_q, sticky_d;

    // Only the last synchroniser stage is seen by the debounce logic.
    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: shift the raw pad level in, cleared by reset/disable.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    // Debounce next-state: a new level is accepted only after it has been
    // seen on DEBOUNCE_CYCLES consecutive samples; any disagreement aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            DB_LOW: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = DB_HIGH;
                        cnt_d   = '0;
                        clean_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = DB_CHK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            DB_CHK_HI: begin
                if (!s) begin
                    state_d = DB_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_HIGH;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DB_HIGH: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = DB_LOW;
                        cnt_d   = '0;
                        clean_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = DB_CHK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            DB_CHK_LO: begin
                if (s) begin
                    state_d = DB_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_LOW;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_LOW;
                cnt_d   = '0;
                clean_d = 1'b0;
            end
        endcase
        // A rise on the same edge as a clear keeps the flag set so no press is lost.
        sticky_d = rise_d | (sticky_q & ~sticky_clr_i);
    end

    // FSM, counter and output registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= DB_LOW;
            cnt_q    <= '0;
            clean_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign clean_o  = clean_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign sticky_o = sticky_q;

endmodule

// File: rtl/team_09_gpio_debounce.sv
// Input conditioning for pads mprj_io[19:16]: NUM_IN independent debounce
// channels. Dropping the wrapper enable holds every channel in reset.
module team_09_gpio_debounce
    import team_09_pkg::*;
#(
    parameter int NUM_IN          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              en,
    input  logic [NUM_IN-1:0] gpio_in,
    input  logic [NUM_IN-1:0] sticky_clr_i,
    output logic [NUM_IN-1:0] clean_o,
    output logic [NUM_IN-1:0] rise_o,
    output logic [NUM_IN-1:0] fall_o,
    output logic [NUM_IN-1:0] sticky_o
);

    logic chan_srst;

    // Reset and disable are handled identically by every channel.
    assign chan_srst = wb_rst_i | ~en;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            team_09_debounce_chan #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_chan (
                .clk_i        (wb_clk_i),
                .srst_i       (chan_srst),
                .pad_i        (gpio_in[gi]),
                .sticky_clr_i (sticky_clr_i[gi]),
                .clean_o      (clean_o[gi]),
                .rise_o       (rise_o[gi]),
                .fall_o       (fall_o[gi]),
                .sticky_o     (sticky_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_team_09_gpio_debounce.sv
// Bench for team_09_gpio_debounce with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
// A run-length model predicts outputs every cycle; directed checks pin key timings.
module tb_team_09_gpio_debounce;

    localparam int N = 4;
    localparam int S = 2;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic [N-1:0] gpio_in = '1;
    logic [N-1:0] sticky_clr = '0;
    logic [N-1:0] clean_o, rise_o, fall_o, sticky_o;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    // Model state: pad samples delayed by the synchroniser, run lengths of the synced level.
    logic [N-1:0] m_pipe [S];
    logic [N-1:0] m_s;
    logic [N-1:0] m_last = '0;
    int           m_run [N];
    logic [N-1:0] exp_clean = '0, exp_rise = '0, exp_fall = '0, exp_sticky = '0;

    team_09_gpio_debounce #(
        .NUM_IN          (N),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .en           (en),
        .gpio_in      (gpio_in),
        .sticky_clr_i (sticky_clr),
        .clean_o      (clean_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .sticky_o     (sticky_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: the clean level switches to the synced level once it has held for D samples.
    initial begin
        for (int k = 0; k < S; k++) m_pipe[k] = '0;
        for (int c = 0; c < N; c++) m_run[c] = 0;
        forever begin
            @(posedge clk);
            if (rst || !en) begin
                for (int k = 0; k < S; k++) m_pipe[k] = '0;
                for (int c = 0; c < N; c++) m_run[c] = 0;
                m_last = '0;
                exp_clean = '0; exp_rise = '0; exp_fall = '0; exp_sticky = '0;
            end else begin
                m_s = m_pipe[S-1];
                for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
                m_pipe[0] = gpio_in;
                exp_rise = '0;
                exp_fall = '0;
                for (int c = 0; c < N; c++) begin
                    if (m_s[c] == m_last[c]) m_run[c] = m_run[c] + 1;
                    else m_run[c] = 1;
                    m_last[c] = m_s[c];
                    if (m_s[c] != exp_clean[c] && m_run[c] >= D) begin
                        exp_clean[c] = m_s[c];
                        if (m_s[c]) exp_rise[c] = 1'b1;
                        else exp_fall[c] = 1'b1;
                    end
                end
                exp_sticky = exp_rise | (exp_sticky & ~sticky_clr);
            end
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("model_clean", 32'(clean_o), 32'(exp_clean));
                check("model_rise", 32'(rise_o), 32'(exp_rise));
                check("model_fall", 32'(fall_o), 32'(exp_fall));
                check("model_sticky", 32'(sticky_o), 32'(exp_sticky));
                check("pulse_excl", 32'(rise_o & fall_o), 32'h0);
            end
        end
    end

    initial begin
        int n_rise;
        int idx;

        // 1. Reset with pads high, then release: rise after 10 edges.
        tick(3);
        cmp_en = 1'b1;
        check("rst_clean", 32'(clean_o), 32'h0);
        check("rst_sticky", 32'(sticky_o), 32'h0);
        rst = 1'b0;
        tick(9);
        check("rel_clean_e9", 32'(clean_o), 32'h0);
        tick(1);
        check("rel_clean_e10", 32'(clean_o), 32'hF);
        check("rel_rise_e10", 32'(rise_o), 32'hF);
        check("rel_sticky", 32'(sticky_o), 32'hF);
        tick(1);
        check("rel_rise_e11", 32'(rise_o), 32'h0);
        gpio_in = 4'h0;
        tick(12);
        check("all_low", 32'(clean_o), 32'h0);
        sticky_clr = 4'hF;
        tick(1);
        sticky_clr = 4'h0;
        check("sticky_cleared", 32'(sticky_o), 32'h0);

        // 2. Glitch on bit0: 5 cycles high must be rejected.
        gpio_in = 4'b0001;
        tick(5);
        gpio_in = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("glitch_clean", 32'(clean_o), 32'h0);
            check("glitch_rise", 32'(rise_o), 32'h0);
        end

        // 3. Press/release on bit2.
        gpio_in = 4'b0100;
        tick(9);
        check("press_rise_e9", 32'(rise_o), 32'h0);
        tick(1);
        check("press_rise_e10", 32'(rise_o), 32'h4);
        check("press_clean", 32'(clean_o), 32'h4);
        tick(10);
        gpio_in = 4'b0000;
        tick(9);
        check("rel_fall_e9", 32'(fall_o), 32'h0);
        check("rel_clean_hold", 32'(clean_o), 32'h4);
        tick(1);
        check("rel_fall_e10", 32'(fall_o), 32'h4);
        check("rel_clean_low", 32'(clean_o), 32'h0);

        // 4. Bounce on bit1, then settle high: exactly one rise, 10 edges after settle.
        gpio_in = 4'b0010; tick(3);
        gpio_in = 4'b0000; tick(3);
        gpio_in = 4'b0010; tick(3);
        gpio_in = 4'b0000; tick(3);
        gpio_in = 4'b0010;
        n_rise = 0;
        idx = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (rise_o[1]) begin
                n_rise++;
                idx = i;
            end
        end
        check("bounce_count", 32'(n_rise), 32'd1);
        check("bounce_latency", 32'(idx), 32'd10);

        // 5. Sticky: clear coinciding with rise loses to the set; next clear wins.
        sticky_clr = 4'hF;
        tick(1);
        sticky_clr = 4'h0;
        check("sticky_clr2", 32'(sticky_o), 32'h0);
        gpio_in = 4'b1010;
        tick(9);
        sticky_clr = 4'b1000;
        tick(1);
        check("sticky_rise3", 32'(rise_o), 32'h8);
        check("sticky_set_wins", 32'(sticky_o), 32'h8);
        tick(1);
        check("sticky_cleared3", 32'(sticky_o), 32'h0);
        sticky_clr = 4'h0;

        // 6. Enable drop mid-debounce on bit0, then full latency again.
        gpio_in = 4'b1011;
        tick(7);
        en = 1'b0;
        tick(1);
        check("en_off_clean", 32'(clean_o), 32'h0);
        check("en_off_fall", 32'(fall_o), 32'h0);
        tick(2);
        en = 1'b1;
        tick(9);
        check("en_on_e9", 32'(clean_o), 32'h0);
        tick(1);
        check("en_on_e10", 32'(clean_o), 32'hB);
        check("en_on_rise", 32'(rise_o), 32'hB);
        tick(3);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
